// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared FSM encodings and beat-counter sizing for sram_responder
package sram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    localparam int WS_W = 4;
    // One bit wider than wait_states so that wait_states+1 = 16 still fits.
    localparam int BEAT_CNT_W = WS_W + 1;

    function automatic logic [BEAT_CNT_W-1:0] beat_load(input int ws);
        return BEAT_CNT_W'(ws + 1);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// rtl/sram_beat_timer.sv - loadable beat down-counter with final-cycle and next-cycle write-strobe flags
module sram_beat_timer
    import sram_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [BEAT_CNT_W-1:0] load_val_i,
    output logic                  last_o,
    output logic                  strobe_we_o
);

    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [BEAT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o      = (cnt_q == '0);
    // Looks one cycle ahead so the top can register we_n directly.
    assign strobe_we_o = (cnt_d != '0);

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - toggle req/ack responder running two half-word SRAM beats; option SRAM_RESPONDER_POSTED_WRITE_EN
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int abits       = 20,
    parameter int dbits       = 32,
    parameter int wait_states = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    output logic               ack,
    input  logic               we,
    input  logic [abits-1:0]   a,
    input  logic [dbits-1:0]   d,
    output logic [dbits-1:0]   q,
    output logic [abits:0]     sram_a,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [dbits/2-1:0] dq_o,
    output logic               dq_oe,
    input  logic [dbits/2-1:0] dq_i
);

    localparam int HW = dbits / 2;

`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    state_e             state_q;
    logic               ack_q;
    logic [dbits-1:0]   q_q;
    logic [abits:0]     sram_a_q;
    logic [HW-1:0]      dq_o_q;
    logic               dq_oe_q;
    logic               ce_n_q;
    logic               oe_n_q;
    logic               we_n_q;
    logic               we_q;
    logic [abits-1:0]   a_q;
    logic [dbits-1:0]   d_q;

    logic pending;
    logic beat_last;
    logic strobe_we;
    logic timer_load;

    assign pending    = (req != ack_q);
    assign timer_load = ((state_q == ST_IDLE) && pending) || ((state_q == ST_LO) && beat_last);

    sram_beat_timer u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (timer_load),
        .en_i        (state_q != ST_IDLE),
        .load_val_i  (beat_load(wait_states)),
        .last_o      (beat_last),
        .strobe_we_o (strobe_we)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            q_q      <= '0;
            sram_a_q <= '0;
            dq_o_q   <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            we_q     <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        we_q     <= we;
                        a_q      <= a;
                        d_q      <= d;
                        sram_a_q <= {a, 1'b0};
                        dq_o_q   <= d[HW-1:0];
                        ce_n_q   <= 1'b0;
                        oe_n_q   <= we;
                        we_n_q   <= ~(we & strobe_we);
                        dq_oe_q  <= we;
                        if (POSTED && we) begin
                            ack_q <= ~ack_q;
                        end
                        state_q  <= ST_LO;
                    end
                end
                ST_LO: begin
                    we_n_q <= ~(we_q & strobe_we);
                    if (beat_last) begin
                        if (!we_q) begin
                            q_q[HW-1:0] <= dq_i;
                        end
                        sram_a_q <= {a_q, 1'b1};
                        dq_o_q   <= d_q[dbits-1:HW];
                        state_q  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (beat_last) begin
                        if (!we_q) begin
                            q_q[dbits-1:HW] <= dq_i;
                        end
                        if (!(POSTED && we_q)) begin
                            ack_q <= ~ack_q;
                        end
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        we_n_q <= ~(we_q & strobe_we);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign q         = q_q;
    assign sram_a    = sram_a_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign dq_o      = dq_o_q;
    assign dq_oe     = dq_oe_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - self-checking bench for sram_responder (wait_states 1 and 0 instances)
module tb_sram_responder;

`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk;
    logic        rst_n_s [2];
    logic        req_s   [2];
    logic        ack_s   [2];
    logic        we_s    [2];
    logic [19:0] a_s     [2];
    logic [31:0] d_s     [2];
    logic [31:0] q_s     [2];
    logic [20:0] sa_s    [2];
    logic        ce_s    [2];
    logic        oe_s    [2];
    logic        wen_s   [2];
    logic        dqoe_s  [2];
    logic [15:0] dqo_s   [2];
    logic [15:0] dqi_s   [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [2][128];
    logic        exp_ack [2];
    logic [31:0] exp_q   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] smem [256] = '{default: 16'h0};

        sram_responder #(
            .abits       (20),
            .dbits       (32),
            .wait_states ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .reset_n   (rst_n_s[g]),
            .req       (req_s[g]),
            .ack       (ack_s[g]),
            .we        (we_s[g]),
            .a         (a_s[g]),
            .d         (d_s[g]),
            .q         (q_s[g]),
            .sram_a    (sa_s[g]),
            .sram_ce_n (ce_s[g]),
            .sram_oe_n (oe_s[g]),
            .sram_we_n (wen_s[g]),
            .dq_o      (dqo_s[g]),
            .dq_oe     (dqoe_s[g]),
            .dq_i      (dqi_s[g])
        );

        always @(posedge clk) begin
            if (!ce_s[g] && !wen_s[g]) smem[sa_s[g][7:0]] <= dqo_s[g];
        end
        assign dqi_s[g] = (!ce_s[g] && !oe_s[g]) ? smem[sa_s[g][7:0]] : 16'h0;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    // Drives one transaction and checks every cycle from the accept edge to the following IDLE cycle.
    task automatic run_txn(input int k, input bit w, input logic [19:0] addr, input logic [31:0] data);
        int bl, n, lat, beat, p;
        logic        ack0, bt;
        logic [3:0]  exp_strb;
        logic [20:0] exp_sa;
        logic [15:0] exp_dqo;
        logic [31:0] exp_rd;
        logic        exp_a;
        bl     = ws_of(k) + 2;
        n      = 2 * bl;
        lat    = (POSTED && w) ? 0 : n;
        exp_rd = ref_mem[k][addr[6:0]];
        @(negedge clk);
        we_s[k]  = w;
        a_s[k]   = addr;
        d_s[k]   = data;
        req_s[k] = ~req_s[k];
        ack0       = exp_ack[k];
        exp_ack[k] = ~exp_ack[k];
        if (w) ref_mem[k][addr[6:0]] = data;
        for (int c = 1; c <= n + 1; c++) begin
            @(posedge clk);
            #1;
            beat = (c - 1) / bl;
            p    = (c - 1) % bl;
            if (c <= n) begin
                exp_strb = {1'b0, w, (w ? (p == bl - 1) : 1'b1), w};
                bt       = (beat != 0);
            end else begin
                exp_strb = 4'b1110;
                bt       = 1'b1;
            end
            exp_sa  = {addr, bt};
            exp_dqo = bt ? data[31:16] : data[15:0];
            exp_a   = (c >= lat + 1) ? ~ack0 : ack0;
            checks++;
            if ({ce_s[k], oe_s[k], wen_s[k], dqoe_s[k]} !== exp_strb) begin
                errors++;
                $display("FAIL strobes k=%0d we=%0d c=%0d got %b exp %b", k, w, c,
                         {ce_s[k], oe_s[k], wen_s[k], dqoe_s[k]}, exp_strb);
            end
            checks++;
            if (sa_s[k] !== exp_sa) begin
                errors++;
                $display("FAIL sram_a k=%0d c=%0d got %h exp %h", k, c, sa_s[k], exp_sa);
            end
            if (w) begin
                checks++;
                if (dqo_s[k] !== exp_dqo) begin
                    errors++;
                    $display("FAIL dq_o k=%0d c=%0d got %h exp %h", k, c, dqo_s[k], exp_dqo);
                end
            end
            checks++;
            if (ack_s[k] !== exp_a) begin
                errors++;
                $display("FAIL ack k=%0d we=%0d c=%0d got %b exp %b", k, w, c, ack_s[k], exp_a);
            end
            if (!w && c == n) begin
                checks++;
                if (q_s[k] !== {exp_q[k][31:16], exp_rd[15:0]}) begin
                    errors++;
                    $display("FAIL q_partial k=%0d got %h exp %h", k, q_s[k], {exp_q[k][31:16], exp_rd[15:0]});
                end
            end
            if (c == n + 1) begin
                checks++;
                if (q_s[k] !== (w ? exp_q[k] : exp_rd)) begin
                    errors++;
                    $display("FAIL q k=%0d we=%0d got %h exp %h", k, w, q_s[k], (w ? exp_q[k] : exp_rd));
                end
            end
        end
        if (!w) exp_q[k] = exp_rd;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst_n_s[k] = 1'b0;
            req_s[k]   = 1'b0;
            we_s[k]    = 1'b0;
            a_s[k]     = '0;
            d_s[k]     = '0;
            exp_ack[k] = 1'b0;
            exp_q[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ack_s[k], ce_s[k], oe_s[k], wen_s[k], dqoe_s[k]} !== 5'b01110) begin
                errors++;
                $display("FAIL reset_ctrl k=%0d got %b exp %b", k,
                         {ack_s[k], ce_s[k], oe_s[k], wen_s[k], dqoe_s[k]}, 5'b01110);
            end
            checks++;
            if ({q_s[k], sa_s[k], dqo_s[k]} !== 69'h0) begin
                errors++;
                $display("FAIL reset_data k=%0d got %h exp 0", k, {q_s[k], sa_s[k], dqo_s[k]});
            end
        end
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({ce_s[k], ack_s[k]} !== 2'b10) begin
                    errors++;
                    $display("FAIL idle_after_reset k=%0d got %b exp 10", k, {ce_s[k], ack_s[k]});
                end
            end
        end
    endtask

    task automatic test_write();
        run_txn(0, 1'b1, 20'h00012, 32'hDEADBEEF);
    endtask

    task automatic test_read();
        run_txn(0, 1'b0, 20'h00012, 32'h0);
        run_txn(0, 1'b1, 20'h00012, 32'h56781234);
        run_txn(0, 1'b0, 20'h00012, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_txn(1, 1'b1, 20'h00005, 32'hA5A55A5A);
        run_txn(1, 1'b0, 20'h00005, 32'h0);
        run_txn(1, 1'b0, 20'h00012, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int          k;
            bit          w;
            logic [19:0] addr;
            k    = int'($urandom_range(0, 1));
            w    = bit'($urandom_range(0, 1));
            addr = 20'($urandom_range(0, 15));
            run_txn(k, w, addr, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        data = $urandom;
        @(negedge clk);
        we_s[0]  = 1'b1;
        a_s[0]   = 20'h00030;
        d_s[0]   = data;
        req_s[0] = ~req_s[0];
        repeat (5) @(posedge clk);
        #2;
        rst_n_s[0] = 1'b0;
        req_s[0]   = 1'b0;
        #1;
        checks++;
        if ({ack_s[0], ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]} !== 5'b01110) begin
            errors++;
            $display("FAIL mid_reset got %b exp %b", {ack_s[0], ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]}, 5'b01110);
        end
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        exp_ack[0] = 1'b0;
        exp_q[0]   = '0;
        run_txn(0, 1'b1, 20'h00030, ~data);
        run_txn(0, 1'b0, 20'h00030, 32'h0);
    endtask

`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
    task automatic test_posted();
        logic        ack0;
        logic [31:0] data;
        data = $urandom;
        ack0 = exp_ack[0];
        @(negedge clk);
        we_s[0]  = 1'b1;
        a_s[0]   = 20'h00040;
        d_s[0]   = data;
        req_s[0] = ~req_s[0];
        ref_mem[0][7'h40] = data;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 || c == 13) begin
                checks++;
                if (ack_s[0] !== ~ack0) begin
                    errors++;
                    $display("FAIL posted_ack c=%0d got %b exp %b", c, ack_s[0], ~ack0);
                end
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({ce_s[0], oe_s[0], dqoe_s[0]} !== 3'b011) begin
                    errors++;
                    $display("FAIL posted_write_beat c=%0d got %b exp 011", c, {ce_s[0], oe_s[0], dqoe_s[0]});
                end
            end
            if (c == 7) begin
                checks++;
                if ({ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]} !== 4'b1110) begin
                    errors++;
                    $display("FAIL posted_idle got %b exp 1110", {ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]});
                end
            end
            if (c == 8) begin
                checks++;
                if ({ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]} !== 4'b0010) begin
                    errors++;
                    $display("FAIL posted_read_accept got %b exp 0010", {ce_s[0], oe_s[0], wen_s[0], dqoe_s[0]});
                end
            end
            if (c == 14) begin
                checks++;
                if ({ack_s[0], q_s[0]} !== {ack0, data}) begin
                    errors++;
                    $display("FAIL posted_read_done got %b/%h exp %b/%h", ack_s[0], q_s[0], ack0, data);
                end
            end
            if (c == 2) begin
                @(negedge clk);
                we_s[0]  = 1'b0;
                req_s[0] = ~req_s[0];
            end
        end
        exp_ack[0] = ack0;
        exp_q[0]   = data;
    endtask
`endif

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 128; i++) ref_mem[k][i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
        test_posted();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
